// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one single-ported MIPS150 memory between the I-fetch and load/store ports.
// One transaction in flight; round-robin on contention; big-endian byte lanes for stores.
module mem_port_arbiter #(
    parameter int AW     = 14,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_memwrite,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic          d_err,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        r_state, w_state;
    logic          r_favor_d, w_favor_d;
    logic          r_port_d, w_port_d;
    logic          r_load, w_load;
    logic [2:0]    r_cnt, w_cnt;
    logic          r_mem_en, w_mem_en;
    logic [3:0]    r_mem_we, w_mem_we;
    logic [AW-3:0] r_mem_addr, w_mem_addr;
    logic [31:0]   r_mem_wdata, w_mem_wdata;
    logic          r_i_done, w_i_done;
    logic          r_d_done, w_d_done;
    logic          r_d_err, w_d_err;
    logic [31:0]   r_i_rdata, w_i_rdata;
    logic [31:0]   r_d_rdata, w_d_rdata;

    logic          w_grant_d, w_grant_i, w_contend, w_misaligned;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic [1:0]    w_unused_ialign;

    // Fetch addresses are word aligned by construction; the byte offset is ignored.
    assign w_unused_ialign = i_addr[1:0];

    assign w_contend = i_req && d_req;
    assign w_grant_d = d_req && (!i_req || r_favor_d);
    assign w_grant_i = i_req && !w_grant_d;
    assign w_misaligned = ((d_memwrite == 2'b10) && d_addr[0]) ||
                          ((d_memwrite == 2'b11) && (d_addr[1:0] != 2'b00));

    // Lane 3 (bits 31:24) is byte offset 0: big-endian enables.
    always_comb begin
        w_be = 4'b0000;
        w_wd = d_wdata;
        case (d_memwrite)
            2'b01: begin
                w_be = 4'b1000 >> d_addr[1:0];
                w_wd = {4{d_wdata[7:0]}};
            end
            2'b10: begin
                w_be = d_addr[1] ? 4'b0011 : 4'b1100;
                w_wd = {2{d_wdata[15:0]}};
            end
            2'b11:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_favor_d   = r_favor_d;
        w_port_d    = r_port_d;
        w_load      = r_load;
        w_cnt       = r_cnt;
        w_mem_en    = r_mem_en;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_i_done    = 1'b0;
        w_d_done    = 1'b0;
        w_d_err     = 1'b0;
        w_i_rdata   = r_i_rdata;
        w_d_rdata   = r_d_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d || w_grant_i) begin
                    // The pointer only moves on contention, so it always favours the last loser.
                    if (w_contend) w_favor_d = w_grant_i;
                    w_port_d = w_grant_d;
                    if (w_grant_d && w_misaligned) begin
                        w_d_done = 1'b1;
                        w_d_err  = 1'b1;
                    end else begin
                        w_state     = S_ISSUE;
                        w_mem_en    = 1'b1;
                        w_load      = w_grant_i || (d_memwrite == 2'b00);
                        w_mem_addr  = w_grant_d ? d_addr[AW-1:2] : i_addr[AW-1:2];
                        w_mem_we    = w_grant_d ? w_be : 4'b0000;
                        w_mem_wdata = w_grant_d ? w_wd : 32'h0;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    w_mem_en = 1'b0;
                    w_mem_we = 4'b0000;
                    if (r_load) begin
                        w_state = S_WAIT;
                        w_cnt   = 3'(RD_LAT);
                    end else begin
                        w_state  = S_IDLE;
                        w_d_done = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_state = S_IDLE;
                    if (r_port_d) begin
                        w_d_rdata = mem_rdata;
                        w_d_done  = 1'b1;
                    end else begin
                        w_i_rdata = mem_rdata;
                        w_i_done  = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt - 3'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_favor_d   <= 1'b1;
            r_port_d    <= 1'b0;
            r_load      <= 1'b0;
            r_cnt       <= 3'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_i_rdata   <= 32'h0;
            r_d_rdata   <= 32'h0;
        end else begin
            r_state     <= w_state;
            r_favor_d   <= w_favor_d;
            r_port_d    <= w_port_d;
            r_load      <= w_load;
            r_cnt       <= w_cnt;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_i_done    <= w_i_done;
            r_d_done    <= w_d_done;
            r_d_err     <= w_d_err;
            r_i_rdata   <= w_i_rdata;
            r_d_rdata   <= w_d_rdata;
        end
    end

    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: byte-addressed reference memory, per-port expectation queues,
// a negedge monitor popping them on every done pulse, and a word-wide BRAM model with RD_LAT.
module tb_mem_port_arbiter;
    localparam int AW     = 14;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [1:0]    d_memwrite;
    logic [31:0]   d_wdata;
    logic          d_done, d_err;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    typedef struct {
        bit          err;
        bit          load;
        logic [31:0] data;
    } dexp_t;

    dexp_t       d_q[$];
    logic [31:0] i_q[$];
    dexp_t       mon_de;
    logic [31:0] mon_ie;
    int checks = 0, failures = 0, cyc = 0, acc_cnt = 0, pend_cnt = 0;
    logic [31:0] pend_data;
    logic [31:0] bram [4096];
    logic [7:0]  ref_b [16384];
    logic [3:0]  last_we;
    logic [31:0] last_wdata;
    logic [AW-3:0] last_addr;

    mem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_memwrite(d_memwrite), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000 ^ 32'(w);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] we, logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (we[l]) r[8*l +: 8] = wd[8*l +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Block RAM stand-in: writes on accept, read data appears RD_LAT cycles after accept.
    always @(posedge clk) begin
        mem_rdata <= $urandom();
        if (pend_cnt == 1) begin
            mem_rdata <= pend_data;
            pend_cnt  <= 0;
        end else if (pend_cnt > 1) begin
            pend_cnt <= pend_cnt - 1;
        end
        if (!rst && mem_en && mem_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (mem_we != 4'b0000) begin
                bram[mem_addr] <= merge(bram[mem_addr], mem_we, mem_wdata);
            end else if (RD_LAT == 1) begin
                mem_rdata <= bram[mem_addr];
            end else begin
                pend_data <= bram[mem_addr];
                pend_cnt  <= RD_LAT - 1;
            end
        end
    end

    // Reference: byte-addressed, big-endian (lowest address = most significant byte).
    task automatic ref_d(input logic [1:0] mw, input logic [AW-1:0] a, input logic [31:0] wd,
                         output dexp_t e);
        int base, n;
        e.err  = 0;
        e.load = (mw == 2'b00);
        e.data = 32'h0;
        base   = int'(a) & ~3;
        if (mw == 2'b00) begin
            e.data = {ref_b[base], ref_b[base+1], ref_b[base+2], ref_b[base+3]};
        end else if ((mw == 2'b10 && a[0]) || (mw == 2'b11 && a[1:0] != 2'b00)) begin
            e.err = 1;
        end else begin
            n = 1 << (int'(mw) - 1);
            for (int k = 0; k < n; k++) ref_b[int'(a) + k] = wd[8*(n-1-k) +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (mem_en) begin
            last_we    <= mem_we;
            last_wdata <= mem_wdata;
            last_addr  <= mem_addr;
        end
        if (i_done) begin
            if (i_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL i_done_unexpected actual=1 expected=0 (t=%0t)", $time);
            end else begin
                mon_ie = i_q.pop_front();
                chk("i_rdata", i_rdata, mon_ie);
            end
        end
        if (d_err && !d_done) chk("d_err_without_done", d_err, 0);
        if (d_done) begin
            if (d_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL d_done_unexpected actual=1 expected=0 (t=%0t)", $time);
            end else begin
                mon_de = d_q.pop_front();
                chk("d_err", d_err, mon_de.err);
                if (mon_de.load) chk("d_rdata", d_rdata, mon_de.data);
            end
        end
    end

    task automatic wait_d(input int t0, output int lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!d_done && n < 200);
        if (!d_done) chk("d_done_timeout", 0, 1);
        lat = cyc - t0;
    endtask

    task automatic wait_i(input int t0, output int lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!i_done && n < 200);
        if (!i_done) chk("i_done_timeout", 0, 1);
        lat = cyc - t0;
    endtask

    task automatic d_txn(input logic [1:0] mw, input logic [AW-1:0] a, input logic [31:0] wd,
                         input bit hold, output int lat);
        dexp_t e;
        int t0;
        ref_d(mw, a, wd, e);
        d_q.push_back(e);
        d_memwrite = mw; d_addr = a; d_wdata = wd; d_req = 1;
        t0 = cyc;
        wait_d(t0, lat);
        if (!hold) d_req = 0;
    endtask

    task automatic i_txn(input logic [AW-1:0] a, input bit hold, output int lat);
        int t0;
        i_q.push_back(init_word(int'(a[AW-1:2])));
        i_addr = a; i_req = 1;
        t0 = cyc;
        wait_i(t0, lat);
        if (!hold) i_req = 0;
    endtask

    task automatic contend(input string name, input bit d_first);
        int ld, li;
        fork
            d_txn(2'b00, 14'h0020, 32'h0, 0, ld);
            i_txn(14'h1000, 0, li);
        join
        chk({name, "_d_lat"}, ld, d_first ? 4 : 8);
        chk({name, "_i_lat"}, li, d_first ? 8 : 4);
        @(negedge clk);
    endtask

    initial begin
        int lat, t0, dones, acc0, exp_acc;
        bit d_fin, i_fin;
        for (int w = 0; w < 4096; w++) begin
            bram[w] = init_word(w);
            for (int b = 0; b < 4; b++) ref_b[4*w + b] = bram[w][8*(3-b) +: 8];
        end
        rst = 1; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_memwrite = 0; d_wdata = 0;
        mem_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_pulses", {i_done, d_done, d_err, mem_en}, 0);
        chk("rst_mem", {mem_we, 16'(mem_addr)}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        rst = 0;
        @(negedge clk);

        d_txn(2'b11, 14'h0010, 32'hDEADBEEF, 0, lat);
        chk("sw_lat", lat, 2);
        chk("sw_addr", last_addr, 12'h004);
        chk("sw_we", last_we, 4'b1111);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        d_txn(2'b01, 14'h0003, 32'h000000AB, 0, lat);
        chk("sb_we", last_we, 4'b0001);
        chk("sb_wdata", last_wdata, 32'hABABABAB);
        d_txn(2'b10, 14'h0002, 32'h00001234, 0, lat);
        chk("sh_we", last_we, 4'b0011);
        chk("sh_wdata", last_wdata, 32'h12341234);
        d_txn(2'b01, 14'h0000, 32'h00000077, 0, lat);
        chk("sb0_we", last_we, 4'b1000);
        d_txn(2'b00, 14'h0001, 32'h0, 0, lat);
        chk("ld_lat", lat, 2 + RD_LAT);
        chk("ld_we", last_we, 4'b0000);
        chk("ld_addr_aligned", last_addr, 12'h000);

        contend("cont1", 1);
        contend("cont2", 0);
        contend("cont3", 1);

        acc0 = acc_cnt;
        d_txn(2'b11, 14'h0006, 32'h11111111, 0, lat);
        chk("mis_sw_lat", lat, 1);
        d_txn(2'b10, 14'h0001, 32'h2222, 0, lat);
        chk("mis_sh_lat", lat, 1);
        @(negedge clk);
        chk("mis_no_access", acc_cnt - acc0, 0);

        // Memory stalls for three ISSUE cycles.
        begin
            dexp_t e;
            ref_d(2'b00, 14'h0040, 32'h0, e);
            d_q.push_back(e);
        end
        mem_ready = 0; d_memwrite = 0; d_addr = 14'h0040; d_req = 1; t0 = cyc;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("stall_en", mem_en, 1);
            chk("stall_addr", mem_addr, 12'h010);
        end
        mem_ready = 1;
        wait_d(t0, lat);
        d_req = 0;
        chk("stall_lat", lat, 7);
        @(negedge clk);

        // Reset while ISSUE is stalled: mem_en falls without a clock edge.
        mem_ready = 0; d_memwrite = 0; d_addr = 14'h0044; d_req = 1;
        @(negedge clk);
        chk("abort_issue_en", mem_en, 1);
        rst = 1; #1;
        chk("abort_issue_en_drop", mem_en, 0);
        d_req = 0; mem_ready = 1;
        @(negedge clk); rst = 0;
        @(negedge clk);
        contend("cont_post_rst1", 1);

        // Reset during WAIT after the pointer has moved to favour I.
        d_memwrite = 0; d_addr = 14'h0048; d_req = 1;
        repeat (2) @(negedge clk);
        rst = 1; #1;
        chk("rstwait_pulses", {i_done, d_done, d_err, mem_en}, 0);
        chk("rstwait_rdata", i_rdata | d_rdata, 0);
        chk("rstwait_we", mem_we, 0);
        d_req = 0;
        @(negedge clk); rst = 0;
        dones = 0;
        repeat (6) begin @(negedge clk); if (i_done || d_done) dones++; end
        chk("rstwait_no_done", dones, 0);
        contend("cont_post_rst2", 1);

        acc0 = acc_cnt; exp_acc = 0; d_fin = 0; i_fin = 0;
        fork
            begin
                for (int j = 0; j < 60; j++) begin
                    logic [1:0] mw;
                    logic [AW-1:0] a;
                    bit hold;
                    int l;
                    mw = 2'($urandom_range(0, 3));
                    a = 14'($urandom_range(0, 14'h0FFF));
                    hold = (j != 59) && ($urandom_range(0, 1) == 1);
                    if (!((mw == 2'b10 && a[0]) || (mw == 2'b11 && a[1:0] != 2'b00))) exp_acc++;
                    d_txn(mw, a, $urandom(), hold, l);
                    if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                d_fin = 1;
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    bit hold;
                    int l;
                    hold = (j != 59) && ($urandom_range(0, 1) == 1);
                    exp_acc++;
                    i_txn(14'(14'h1000 + 4 * $urandom_range(0, 1023)), hold, l);
                    if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                i_fin = 1;
            end
            while (!(d_fin && i_fin)) begin
                @(negedge clk);
                mem_ready = ($urandom_range(0, 3) != 0);
            end
        join
        mem_ready = 1;
        repeat (4) @(negedge clk);
        chk("rand_access_count", acc_cnt - acc0, exp_acc);
        chk("queues_drained", d_q.size() + i_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
